systolic_array_os: RTL and testbench

Next-generation output-stationary systolic array. It has a parameterised grid, reduction length K chosen per job, and internal operand skewing with a gated clock enable. A start/done job FSM controls each job, with valid/ready handshakes on operand input and result drain. The block sits between the operand feeders (activation rows and weight columns) and the result writeback path, and computes C = A x B for an NUM_ROW x K by K x NUM_COL job.

---
 rtl/sa_pkg.sv | 27 ++
 rtl/sa_pe.sv | 63 ++++++
 rtl/systolic_array_os.sv | 195 +++++++++++++++++++
 tb/tb_systolic_array_os.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator clamp bounds for a w-bit result (w <= 64), low w bits meaningful.
    function automatic logic [63:0] sat_hi(input int w, input bit sgn);
        if (sgn) return (64'd1 << (w - 1)) - 64'd1;
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_lo(input int w, input bit sgn);
        return sgn ? (64'd1 << (w - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Single output-stationary PE: multiply-accumulate with operand forwarding.
module sa_pe
    import sa_pkg::*;
#(
    parameter int IN_WORD_SIZE  = 8,
    parameter int OUT_WORD_SIZE = 24,
    parameter bit SIGNED        = 1,
    parameter bit SATURATE      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [IN_WORD_SIZE-1:0]  a_i,
    input  logic [IN_WORD_SIZE-1:0]  b_i,
    output logic [IN_WORD_SIZE-1:0]  a_o,
    output logic [IN_WORD_SIZE-1:0]  b_o,
    output logic [OUT_WORD_SIZE-1:0] acc_o,
    output logic                     sat_o
);
    localparam int IN  = IN_WORD_SIZE;
    localparam int OUT = OUT_WORD_SIZE;
    localparam logic [OUT-1:0] HI = OUT'(sat_hi(OUT, SIGNED));
    localparam logic [OUT-1:0] LO = OUT'(sat_lo(OUT, SIGNED));

    logic [IN-1:0]  a_q, b_q;
    logic [OUT-1:0] acc_q, acc_d;
    logic           sat_q, ovf;
    logic [OUT:0]   a_x, b_x, prod_x, acc_x, sum;

    // Low OUT+1 bits of the extended product are exact for either signedness.
    assign a_x    = {{(OUT + 1 - IN){SIGNED && a_i[IN-1]}}, a_i};
    assign b_x    = {{(OUT + 1 - IN){SIGNED && b_i[IN-1]}}, b_i};
    assign prod_x = a_x * b_x;
    assign acc_x  = {SIGNED && acc_q[OUT-1], acc_q};
    assign sum    = acc_x + prod_x;
    assign ovf    = SIGNED ? (sum[OUT] ^ sum[OUT-1]) : sum[OUT];

    always_comb begin
        acc_d = sum[OUT-1:0];
        if (SATURATE && ovf) acc_d = (SIGNED && sum[OUT]) ? LO : HI;
    end

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
            sat_q <= sat_q | (SATURATE && ovf);
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary systolic array: job FSM, operand skew, PE grid and row drain.
module systolic_array_os
    import sa_pkg::*;
#(
    parameter int NUM_ROW       = 4,
    parameter int NUM_COL       = 4,
    parameter int IN_WORD_SIZE  = 8,
    parameter int OUT_WORD_SIZE = 24,
    parameter int MAX_K         = 256,
    parameter bit SIGNED        = 1,
    parameter bit SATURATE      = 1,
    localparam int KW  = $clog2(MAX_K + 1),
    localparam int RIW = clog2_min1(NUM_ROW)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [KW-1:0]                      k_len,
    output logic                               busy,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_ROW*IN_WORD_SIZE-1:0]    left_inputs,
    input  logic [NUM_COL*IN_WORD_SIZE-1:0]    top_inputs,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_COL*OUT_WORD_SIZE-1:0]   out_row_vals,
    output logic [RIW-1:0]                     out_row_idx,
    output logic                               sat_flag,
    output logic [OUT_WORD_SIZE-1:0]           cycles_count,
    output logic                               done
);
    localparam int IN  = IN_WORD_SIZE;
    localparam int OUT = OUT_WORD_SIZE;
    localparam int F   = NUM_ROW + NUM_COL - 2;
    localparam int FW  = clog2_min1(F + 1);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, beat_q;
    logic [FW-1:0]  flush_q;
    logic [RIW-1:0] row_q;
    logic [OUT-1:0] cyc_q;
    logic           adv, job_start;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        adv       = 1'b0;
        job_start = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                job_start = 1'b1;
                state_d   = (k_len == '0) ? DRAIN : FEED;
            end
            FEED: begin
                in_ready = 1'b1;
                adv      = in_valid;
                if (in_valid && beat_q == k_q - KW'(1)) state_d = (F == 0) ? DRAIN : FLUSH;
            end
            FLUSH: begin
                adv = 1'b1;
                if (F == 0 || flush_q == FW'(F - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && row_q == RIW'(NUM_ROW - 1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (job_start) begin
                k_q     <= k_len;
                beat_q  <= '0;
                flush_q <= '0;
                row_q   <= '0;
                cyc_q   <= '0;
            end else begin
                if (adv && state_q == FEED) beat_q <= beat_q + KW'(1);
                if (state_q == FLUSH)       flush_q <= flush_q + FW'(1);
                if (out_valid && out_ready) row_q <= row_q + RIW'(1);
                if (busy && cyc_q != '1)    cyc_q <= cyc_q + OUT'(1);
            end
        end
    end

    // Edge operands; zeros are injected outside FEED so FLUSH pushes bubbles.
    logic [NUM_ROW-1:0][IN-1:0] a_edge;
    logic [NUM_COL-1:0][IN-1:0] b_edge;

    for (genvar r = 0; r < NUM_ROW; r++) begin : g_lskew
        logic [IN-1:0] feed;
        assign feed = (state_q == FEED) ? left_inputs[r*IN +: IN] : '0;
        if (r == 0) begin : g_direct
            assign a_edge[r] = feed;
        end else begin : g_delay
            logic [r-1:0][IN-1:0] sh_q;
            always_ff @(posedge clk) begin
                if (reset || job_start) sh_q <= '0;
                else if (adv) begin
                    sh_q[0] <= feed;
                    for (int i = 1; i < r; i++) sh_q[i] <= sh_q[i-1];
                end
            end
            assign a_edge[r] = sh_q[r-1];
        end
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : g_tskew
        logic [IN-1:0] feed;
        assign feed = (state_q == FEED) ? top_inputs[c*IN +: IN] : '0;
        if (c == 0) begin : g_direct
            assign b_edge[c] = feed;
        end else begin : g_delay
            logic [c-1:0][IN-1:0] sh_q;
            always_ff @(posedge clk) begin
                if (reset || job_start) sh_q <= '0;
                else if (adv) begin
                    sh_q[0] <= feed;
                    for (int i = 1; i < c; i++) sh_q[i] <= sh_q[i-1];
                end
            end
            assign b_edge[c] = sh_q[c-1];
        end
    end

    logic [NUM_ROW-1:0][NUM_COL-1:0][IN-1:0]  a_out, b_out;
    logic [NUM_ROW-1:0][NUM_COL-1:0][OUT-1:0] acc;
    logic [NUM_ROW-1:0][NUM_COL-1:0]          pe_sat;

    for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
        for (genvar c = 0; c < NUM_COL; c++) begin : g_col
            logic [IN-1:0] a_in, b_in;
            if (c == 0) begin : g_ae
                assign a_in = a_edge[r];
            end else begin : g_af
                assign a_in = a_out[r][c-1];
            end
            if (r == 0) begin : g_be
                assign b_in = b_edge[c];
            end else begin : g_bf
                assign b_in = b_out[r-1][c];
            end
            sa_pe #(
                .IN_WORD_SIZE (IN),
                .OUT_WORD_SIZE(OUT),
                .SIGNED       (SIGNED),
                .SATURATE     (SATURATE)
            ) u_pe (
                .clk  (clk),
                .reset(reset),
                .en_i (adv),
                .clr_i(job_start),
                .a_i  (a_in),
                .b_i  (b_in),
                .a_o  (a_out[r][c]),
                .b_o  (b_out[r][c]),
                .acc_o(acc[r][c]),
                .sat_o(pe_sat[r][c])
            );
        end
    end

    // Operands leaving the far edge of the grid have no consumer.
    logic unused_fwd;
    assign unused_fwd = ^{a_out, b_out};

    always_comb begin
        out_row_vals = '0;
        if (out_valid)
            for (int c = 0; c < NUM_COL; c++) out_row_vals[c*OUT +: OUT] = acc[row_q][c];
    end

    assign out_row_idx  = out_valid ? row_q : '0;
    assign sat_flag     = |pe_sat;
    assign cycles_count = cyc_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Randomized self-checking bench: 2x2 signed array plus 1x1 saturating/wrapping pair.
module tb_systolic_array_os;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // 2x2, IN=8, OUT=24, signed, saturating
    logic        start, in_valid, out_ready, busy, in_ready, out_valid, sat_flag, done;
    logic [8:0]  k_len;
    logic [15:0] left_inputs, top_inputs;
    logic [47:0] out_row_vals;
    logic [0:0]  out_row_idx;
    logic [23:0] cycles_count;

    systolic_array_os #(.NUM_ROW(2), .NUM_COL(2), .IN_WORD_SIZE(8), .OUT_WORD_SIZE(24),
                        .MAX_K(256), .SIGNED(1), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .left_inputs(left_inputs), .top_inputs(top_inputs),
        .out_valid(out_valid), .out_ready(out_ready), .out_row_vals(out_row_vals),
        .out_row_idx(out_row_idx), .sat_flag(sat_flag), .cycles_count(cycles_count), .done(done));

    // 1x1 pair, IN=8, OUT=16, shared inputs
    logic        s_start, s_in_valid, s_out_ready;
    logic [8:0]  s_k_len;
    logic [7:0]  s_left, s_top;
    logic        ss_busy, ss_in_ready, ss_out_valid, ss_sat, ss_done;
    logic        sw_busy, sw_in_ready, sw_out_valid, sw_sat, sw_done;
    logic [15:0] ss_vals, sw_vals, ss_cyc, sw_cyc;
    logic [0:0]  ss_idx, sw_idx;

    systolic_array_os #(.NUM_ROW(1), .NUM_COL(1), .IN_WORD_SIZE(8), .OUT_WORD_SIZE(16),
                        .MAX_K(256), .SIGNED(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .k_len(s_k_len), .busy(ss_busy),
        .in_valid(s_in_valid), .in_ready(ss_in_ready), .left_inputs(s_left), .top_inputs(s_top),
        .out_valid(ss_out_valid), .out_ready(s_out_ready), .out_row_vals(ss_vals),
        .out_row_idx(ss_idx), .sat_flag(ss_sat), .cycles_count(ss_cyc), .done(ss_done));

    systolic_array_os #(.NUM_ROW(1), .NUM_COL(1), .IN_WORD_SIZE(8), .OUT_WORD_SIZE(16),
                        .MAX_K(256), .SIGNED(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .start(s_start), .k_len(s_k_len), .busy(sw_busy),
        .in_valid(s_in_valid), .in_ready(sw_in_ready), .left_inputs(s_left), .top_inputs(s_top),
        .out_valid(sw_out_valid), .out_ready(s_out_ready), .out_row_vals(sw_vals),
        .out_row_idx(sw_idx), .sat_flag(sw_sat), .cycles_count(sw_cyc), .done(sw_done));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w, inout bit hit);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        if (v > hi) begin hit = 1; return hi; end
        if (v < lo) begin hit = 1; return lo; end
        return v;
    endfunction

    function automatic longint wrapw(input longint v, input int w);
        longint m = v & ((longint'(1) <<< w) - 1);
        if (m >= (longint'(1) <<< (w - 1))) m -= (longint'(1) <<< w);
        return m;
    endfunction

    function automatic longint sx24(input logic [23:0] v);
        logic signed [23:0] s = v;
        return longint'(s);
    endfunction

    function automatic longint sx16(input logic [15:0] v);
        logic signed [15:0] s = v;
        return longint'(s);
    endfunction

    int     A[2][64], B[64][2];
    int     a1[64], b1[64];
    longint expC[2][2];
    bit     expSat;

    function automatic int rnd8();
        return int'($urandom % 256) - 128;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".vals"}, out_row_vals, 0);
        chk({tag, ".idx"}, out_row_idx, 0);
        chk({tag, ".sat"}, sat_flag, 0);
        chk({tag, ".cycles"}, cycles_count, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    // smode: 0 none, 1 three stalls before beat 1, 2 random; bmode: 0 none, 1 four holds on row 0, 2 random
    task automatic run22(input int K, input int smode, input int bmode, input bit junk, input string nm);
        int t = 0, row = 0, cyc = 0, stalls = 0, holds = 0, first_v = -1, done_c = -1;
        bit prev_hold = 0, v, sat_at_done = 0;
        logic [47:0] prev_vals = '0;
        logic [0:0]  prev_idx = '0;
        expSat = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                longint acc = 0;
                for (int k = 0; k < K; k++) acc = clampw(acc + longint'(A[r][k]) * B[k][c], 24, expSat);
                expC[r][c] = acc;
            end
        @(negedge clk);
        start = 1; k_len = 9'(K); in_valid = 0; out_ready = 0;
        for (int i = 0; i < 3000 && done_c < 0; i++) begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (done) begin
                done_c = cyc;
                sat_at_done = sat_flag;
            end
            if (junk && busy && !done) begin
                start = 1'($urandom % 2);
                k_len = 9'($urandom % 9);
            end
            out_ready = 0;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (prev_hold) begin
                    chk({nm, ".hold_vals"}, out_row_vals, prev_vals);
                    chk({nm, ".hold_idx"}, out_row_idx, prev_idx);
                end
                chk({nm, ".row_idx"}, out_row_idx, row);
                case (bmode)
                    0: out_ready = 1;
                    1: out_ready = !(row == 0 && holds < 4);
                    default: out_ready = ($urandom % 10) < 6;
                endcase
                if (out_ready) begin
                    for (int c = 0; c < 2; c++) chk({nm, ".C"}, sx24(out_row_vals[c*24 +: 24]), expC[row][c]);
                    row++;
                    prev_hold = 0;
                end else begin
                    holds++;
                    prev_hold = 1;
                    prev_vals = out_row_vals;
                    prev_idx  = out_row_idx;
                end
            end
            left_inputs = 16'($urandom);
            top_inputs  = 16'($urandom);
            in_valid    = 0;
            if (in_ready) begin
                case (smode)
                    0: v = 1;
                    1: v = !(t == 1 && stalls < 3);
                    default: v = ($urandom % 10) < 7;
                endcase
                if (v) begin
                    in_valid    = 1;
                    left_inputs = {A[1][t][7:0], A[0][t][7:0]};
                    top_inputs  = {B[t][1][7:0], B[t][0][7:0]};
                    t++;
                end else stalls++;
            end
        end
        start = 0; in_valid = 0; out_ready = 0;
        if (done_c < 0) chk({nm, ".timeout"}, 0, 1);
        else begin
            chk({nm, ".rows"}, row, 2);
            chk({nm, ".first_valid"}, first_v, (K == 0) ? 1 : 1 + K + stalls + 2);
            chk({nm, ".done_cycle"}, done_c, first_v + 2 + holds);
            chk({nm, ".sat"}, sat_at_done, expSat);
            @(negedge clk);
            chk({nm, ".cycles"}, cycles_count, done_c);
            chk({nm, ".busy_after"}, busy, 0);
            chk({nm, ".done_once"}, done, 0);
        end
    endtask

    task automatic run11(input int K, input string nm);
        int t = 0, cyc = 0, got = 0, done_c = -1;
        bit hit = 0;
        longint es = 0, ew = 0;
        for (int k = 0; k < K; k++) begin
            es = clampw(es + longint'(a1[k]) * b1[k], 16, hit);
            ew = wrapw(ew + longint'(a1[k]) * b1[k], 16);
        end
        @(negedge clk);
        s_start = 1; s_k_len = 9'(K); s_in_valid = 0;
        for (int i = 0; i < 1000 && done_c < 0; i++) begin
            @(negedge clk);
            cyc++;
            s_start = 0;
            if (ss_done) done_c = cyc;
            if (ss_out_valid) begin
                chk({nm, ".sat_val"}, sx16(ss_vals), es);
                chk({nm, ".wrap_val"}, sx16(sw_vals), ew);
                chk({nm, ".sat_flag"}, ss_sat, hit);
                chk({nm, ".wrap_flag"}, sw_sat, 0);
                chk({nm, ".wrap_valid"}, sw_out_valid, 1);
                chk({nm, ".latency"}, cyc, 1 + K);
                got++;
            end
            s_in_valid = 0;
            if (ss_in_ready && t < K) begin
                s_in_valid = 1;
                s_left = a1[t][7:0];
                s_top  = b1[t][7:0];
                t++;
            end
        end
        s_in_valid = 0;
        if (done_c < 0) chk({nm, ".timeout"}, 0, 1);
        else begin
            chk({nm, ".rows"}, got, 1);
            @(negedge clk);
            chk({nm, ".cycles"}, ss_cyc, done_c);
        end
    endtask

    initial begin
        reset = 1; start = 0; k_len = 0; in_valid = 0; out_ready = 0;
        left_inputs = 0; top_inputs = 0;
        s_start = 0; s_k_len = 0; s_in_valid = 0; s_out_ready = 1; s_left = 0; s_top = 0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 0;

        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
        run22(2, 0, 0, 0, "basic");
        run22(2, 1, 0, 0, "stall");
        run22(2, 0, 1, 0, "bp");
        run22(0, 0, 0, 0, "kzero");
        run22(2, 2, 2, 1, "busy_start");

        // Reset during FEED, then a clean job must see no stale skew state
        @(negedge clk);
        start = 1; k_len = 5;
        @(negedge clk);
        start = 0; in_valid = 1; left_inputs = 16'h7f7f; top_inputs = 16'h7f7f;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        in_valid = 0;
        chk_idle("midreset");
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            A[0][k] = rnd8(); A[1][k] = rnd8(); B[k][0] = rnd8(); B[k][1] = rnd8();
        end
        run22(3, 0, 0, 0, "post_reset");

        for (int j = 0; j < 12; j++) begin
            int K = int'($urandom_range(1, 12));
            for (int k = 0; k < K; k++) begin
                A[0][k] = rnd8(); A[1][k] = rnd8(); B[k][0] = rnd8(); B[k][1] = rnd8();
            end
            run22(K, int'($urandom % 3), int'($urandom % 3), 1'($urandom % 2), "rand22");
        end

        for (int k = 0; k < 3; k++) begin a1[k] = 127; b1[k] = 127; end
        run11(3, "sat127");
        for (int j = 0; j < 8; j++) begin
            int K = int'($urandom_range(1, 8));
            bit big = 1'($urandom % 2);
            bit neg = 1'($urandom % 2);
            for (int k = 0; k < K; k++) begin
                if (big) begin
                    a1[k] = int'($urandom_range(100, 127));
                    b1[k] = neg ? -int'($urandom_range(100, 128)) : int'($urandom_range(100, 127));
                end else begin
                    a1[k] = rnd8(); b1[k] = rnd8();
                end
            end
            run11(K, "rand11");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
